// File: rtl/ram_indirect.sv
// Data RAM with a 16-word special-register window (wreg mirror, carry/zero flags, INDFn/FSRn pointer pairs).
// Optional macro FSR_AUTOINC_EN: every INDFn access post-increments its FSRn.
module ram_indirect #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int SFR_BASE   = 'h200,
  parameter int NUM_PTR    = 2
) (
  input  logic                  clk,
  input  logic                  reset_bar,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [DATA_WIDTH-1:0] wreg,
  input  logic                  carry_in,
  input  logic                  zero_in,
  output logic                  carry_out,
  output logic                  zero_out
);

  localparam logic [ADDR_WIDTH-1:0] WIN_BASE = ADDR_WIDTH'(SFR_BASE);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  carry_q, carry_d;
  logic                  zero_q, zero_d;
  logic [ADDR_WIDTH-1:0] fsr_q [NUM_PTR];
  logic [ADDR_WIDTH-1:0] fsr_d [NUM_PTR];
  logic                  rst_done_q;

  logic                  in_win;
  logic [3:0]            off;
  logic                  wr_ok;
  logic                  ram_hit;
  logic [ADDR_WIDTH-1:0] ram_addr;

  // The first edge after reset release only arms writes; it never performs one.
  assign wr_ok = write_enable & rst_done_q;

  always_comb begin
    in_win     = (addr[ADDR_WIDTH-1:4] == WIN_BASE[ADDR_WIDTH-1:4]);
    off        = addr[3:0];
    carry_d    = carry_in;
    zero_d     = zero_in;
    fsr_d      = fsr_q;
    ram_addr   = addr;
    ram_hit    = !in_win;
    out_data_d = '0;
    if (in_win) begin
      case (off)
        4'd0: out_data_d = wreg;
        4'd1: begin
          if (wr_ok) carry_d = in_data[0];
          out_data_d = DATA_WIDTH'(carry_d);
        end
        4'd2: begin
          if (wr_ok) zero_d = in_data[0];
          out_data_d = DATA_WIDTH'(zero_d);
        end
        default: begin
          for (int n = 0; n < NUM_PTR; n++) begin
            if (off == 4'(3 + 2 * n)) begin
              // Pointers into the window itself read 0 and drop writes.
              ram_addr = fsr_q[n];
              ram_hit  = (fsr_q[n][ADDR_WIDTH-1:4] != WIN_BASE[ADDR_WIDTH-1:4]);
`ifdef FSR_AUTOINC_EN
              fsr_d[n] = fsr_q[n] + ADDR_WIDTH'(1);
`endif
            end
            if (off == 4'(4 + 2 * n)) begin
              if (wr_ok) fsr_d[n] = in_data[ADDR_WIDTH-1:0];
              out_data_d = DATA_WIDTH'(fsr_d[n]);
            end
          end
        end
      endcase
    end
    if (ram_hit) out_data_d = wr_ok ? in_data : mem[ram_addr];
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      out_data_q <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      rst_done_q <= 1'b0;
      for (int n = 0; n < NUM_PTR; n++) fsr_q[n] <= '0;
    end else begin
      out_data_q <= out_data_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      rst_done_q <= 1'b1;
      fsr_q      <= fsr_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_hit && wr_ok) mem[ram_addr] <= in_data;
  end

  assign out_data  = out_data_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;

endmodule

// File: tb/tb_ram_indirect.sv
// Directed bench for ram_indirect: reads are queued with expected data and checked by a monitor one edge later.
module tb_ram_indirect;
  localparam int DW = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset_bar = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] out_data;
  logic [DW-1:0] wreg = 16'hA5A5;
  logic          carry_in = 1'b0;
  logic          zero_in = 1'b0;
  logic          carry_out;
  logic          zero_out;
  logic          chk_in = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] tag_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  ram_indirect dut (
    .clk(clk), .reset_bar(reset_bar), .addr(addr), .in_data(in_data),
    .write_enable(write_enable), .out_data(out_data), .wreg(wreg),
    .carry_in(carry_in), .zero_in(zero_in), .carry_out(carry_out), .zero_out(zero_out)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus; when chk is set the read result is expected at the next edge.
  task automatic step(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                      input logic ci, input logic chk, input logic [DW-1:0] exp);
    @(negedge clk);
    addr = a; write_enable = we; in_data = d; carry_in = ci; chk_in = chk;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(a);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flags_after_edge(input string name, input logic c, input logic z);
    @(posedge clk);
    #1;
    check_bit({name, "_carry"}, carry_out, c);
    check_bit({name, "_zero"}, zero_out, z);
  endtask

  // Monitor: out_data after each edge whose stimulus requested a check.
  initial begin
    logic          pend;
    logic [DW-1:0] e;
    logic [AW-1:0] t;
    forever begin
      @(posedge clk);
      pend = chk_in;
      #1;
      if (pend) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_underflow: got %h with no expected entry", out_data);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL rd@%h: got %h expected %h", t, out_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: bench did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1 reset_bar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_word("rst_out", out_data, 16'h0000);
    check_bit("rst_carry", carry_out, 1'b0);
    check_bit("rst_zero", zero_out, 1'b0);
    @(negedge clk);
    reset_bar = 1'b1;
    step(11'h000, 1'b0, '0, 1'b0, 1'b0, '0);

    // RAM direct write-first and one-cycle reads
    step(11'h000, 1'b1, 16'hDEAD, 1'b0, 1'b1, 16'hDEAD);
    step(11'h001, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF);
    step(11'h000, 1'b0, '0,       1'b0, 1'b1, 16'hDEAD);
    step(11'h001, 1'b0, '0,       1'b0, 1'b1, 16'hBEEF);

    // INDF0 through FSR0
    step(11'h204, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001);
    step(11'h203, 1'b0, '0,       1'b0, 1'b1, 16'hBEEF);
    step(11'h204, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001);
    step(11'h203, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234);
    step(11'h001, 1'b0, '0,       1'b0, 1'b1, 16'h1234);

    // wreg mirror is read-only
    step(11'h200, 1'b1, 16'h7777, 1'b0, 1'b1, 16'hA5A5);
    step(11'h200, 1'b0, '0,       1'b0, 1'b1, 16'hA5A5);

    // Carry flag
    step(11'h201, 1'b0, '0,       1'b1, 1'b1, 16'h0001);
    step(11'h201, 1'b0, '0,       1'b1, 1'b1, 16'h0001);
    step(11'h201, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000);
    flags_after_edge("carry_wr", 1'b0, 1'b0);
    step(11'h201, 1'b0, '0,       1'b1, 1'b1, 16'h0001);
    flags_after_edge("carry_rel", 1'b1, 1'b0);

    // Zero flag write, then it follows zero_in again
    step(11'h202, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001);
    flags_after_edge("zero_wr", 1'b1, 1'b1);
    step(11'h202, 1'b0, '0,       1'b1, 1'b1, 16'h0000);
    flags_after_edge("zero_rel", 1'b1, 1'b0);

    // FSR1 pointing into the window: write dropped, read 0
    step(11'h206, 1'b1, 16'h0202, 1'b1, 1'b1, 16'h0202);
    step(11'h205, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0000);
    flags_after_edge("indf_win", 1'b1, 1'b0);
    step(11'h205, 1'b0, '0,       1'b1, 1'b1, 16'h0000);
    step(11'h202, 1'b0, '0,       1'b1, 1'b1, 16'h0000);

    // Unmapped window offset
    step(11'h20F, 1'b1, 16'hABCD, 1'b1, 1'b1, 16'h0000);
    step(11'h20F, 1'b0, '0,       1'b1, 1'b1, 16'h0000);

    // FSR truncation and the top RAM address
    step(11'h7FF, 1'b1, 16'h4242, 1'b1, 1'b1, 16'h4242);
    step(11'h204, 1'b1, 16'hF7FF, 1'b1, 1'b1, 16'h07FF);
`ifdef FSR_AUTOINC_EN
    step(11'h203, 1'b0, '0,       1'b1, 1'b1, 16'h4242);
    step(11'h203, 1'b0, '0,       1'b1, 1'b1, 16'hDEAD);
    step(11'h204, 1'b0, '0,       1'b1, 1'b1, 16'h0001);
`else
    step(11'h203, 1'b0, '0,       1'b1, 1'b1, 16'h4242);
    step(11'h203, 1'b0, '0,       1'b1, 1'b1, 16'h4242);
    step(11'h204, 1'b0, '0,       1'b1, 1'b1, 16'h07FF);
`endif

    // Reset in the middle of a write burst
    step(11'h010, 1'b1, 16'h0101, 1'b1, 1'b1, 16'h0101);
    step(11'h011, 1'b1, 16'h0202, 1'b1, 1'b1, 16'h0202);
    @(negedge clk);
    addr = 11'h012; write_enable = 1'b1; in_data = 16'h0303; chk_in = 1'b0;
    #2 reset_bar = 1'b0;
    #1;
    check_word("midrst_out", out_data, 16'h0000);
    check_bit("midrst_carry", carry_out, 1'b0);
    check_bit("midrst_zero", zero_out, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_bar = 1'b1;
    addr = 11'h000; write_enable = 1'b1; in_data = 16'h5555;
    step(11'h000, 1'b0, '0, 1'b1, 1'b1, 16'hDEAD);
    step(11'h204, 1'b0, '0, 1'b1, 1'b1, 16'h0000);
    step(11'h206, 1'b0, '0, 1'b1, 1'b1, 16'h0000);
    step(11'h011, 1'b0, '0, 1'b1, 1'b1, 16'h0202);

    @(negedge clk);
    chk_in = 1'b0; write_enable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_indirect.md
RAM_INDIRECT -- requirements
Module: ram_indirect

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL provide parameter ADDR_WIDTH, default 11, address width in bits; array depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL provide parameter SFR_BASE, default 11'h200, base of the 16-word special-register window.
REQ-004 The block SHALL provide parameter NUM_PTR, default 2, range 1..4, the number of indirect pointer pairs (INDFn/FSRn).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_bar  input  1  reset; asynchronous and active-low.
REQ-007 addr  input  ADDR_WIDTH  access address.
REQ-008 in_data  input  DATA_WIDTH  write data.
REQ-009 write_enable  input  1  write strobe, sampled at rising clk.
REQ-010 out_data  output  DATA_WIDTH  registered read data.
REQ-011 wreg  input  DATA_WIDTH  working-register value, mirrored read-only.
REQ-012 carry_in, zero_in  input  1 each  ALU flag updates.
REQ-013 carry_out, zero_out  output  1 each  flag register values.

Function
REQ-014 Window map SHALL be: +0 wreg (RO), +1 carry, +2 zero, +(3+2n) INDFn, +(4+2n) FSRn for n < NUM_PTR; other window offsets SHALL read 0 and ignore writes.
REQ-015 Addresses outside the window SHALL access the RAM array directly.
REQ-016 Read latency SHALL be one cycle: out_data at edge k+1 reflects addr at edge k.
REQ-017 Reads SHALL be write-first: if write_enable at an edge, out_data takes the post-write value of the addressed location (wreg for +0; 0 for unmapped).
REQ-018 Carry register SHALL load in_data[0] when written via +1, otherwise carry_in each cycle; zero register likewise via +2/zero_in; carry_out/zero_out SHALL be these registers.
REQ-019 Carry/zero reads SHALL return the flag zero-extended to DATA_WIDTH.
REQ-020 FSRn SHALL be ADDR_WIDTH bits; writes take in_data[ADDR_WIDTH-1:0]; reads zero-extend.
REQ-021 INDFn access SHALL read/write RAM[FSRn], with the same latency and write-first rule.
REQ-022 If FSRn points inside the window, INDFn reads SHALL return 0 and writes SHALL be dropped (no recursion).
REQ-023 Writes to wreg offset SHALL be ignored.

Reset
REQ-024 While reset_bar is low: out_data = 0, carry_out = 0, zero_out = 0, all FSRn = 0, asynchronously.
REQ-025 RAM array contents SHALL NOT be reset and SHALL be preserved across reset.
REQ-026 A write asserted on the edge coincident with reset release SHALL be dropped; the first honoured write is at the following edge.

Configuration
REQ-027 With macro FSR_AUTOINC_EN defined, every INDFn access (read or write, including dropped ones per REQ-022) SHALL post-increment FSRn by 1 at that edge, wrapping 2**ADDR_WIDTH-1 to 0.
REQ-028 Without FSR_AUTOINC_EN, FSRn SHALL change only by direct write or reset.

Verification
REQ-029 Write 16'hDEAD @0x000, then 16'hBEEF @0x001, read both -> out_data DEAD then BEEF, each one cycle after addr.
REQ-030 Write FSR0 (0x204) = 0x001, read INDF0 (0x203) -> BEEF; write 16'h1234 via INDF0, read 0x001 -> 1234.
REQ-031 carry_in=1 two cycles, read 0x201 -> 0001; write 0 to 0x201 -> same-cycle read 0000, carry_out 0; drop write_enable -> 0001 next cycle.
REQ-032 FSR1 (0x206) = 0x202, write INDF1 (0x205) 16'hFFFF -> zero_out unchanged; read INDF1 -> 0000.
REQ-033 FSR_AUTOINC_EN: FSR0 = 0x7FF, read INDF0 twice -> RAM[0x7FF] then RAM[0x000]; FSR0 reads 0x001.
REQ-034 Pull reset_bar low mid-write burst -> outputs/FSRs 0 immediately; previously written 0x000 still reads DEAD after release.
